// File: rtl/wdt_pkg.sv
// Shared constants and FSM state types for the windowed watchdog.
package wdt_pkg;
    localparam logic [2:0] FLT_NONE  = 3'b000;
    localparam logic [2:0] FLT_TMO   = 3'b001;
    localparam logic [2:0] FLT_EARLY = 3'b011;
    localparam logic [2:0] FLT_CFG   = 3'b100;

    localparam logic [1:0] A_FRAME = 2'b00;
    localparam logic [1:0] A_SERV  = 2'b01;
    localparam logic [1:0] A_CTRL  = 2'b10;
    localparam logic [1:0] A_RLIM  = 2'b11;

    localparam int unsigned KICK_B = 3;
    localparam int unsigned MODE_B = 0;
    localparam int unsigned FCNT_W = 4;

    typedef enum logic [1:0] {U_LOCKED, U_ARMED, U_OPEN} unlock_state_t;
    typedef enum logic [1:0] {W_IDLE, W_RUN, W_RSTP} wdt_state_t;
endpackage

// File: rtl/wdt_unlock.sv
// Key sequence detector; opens a WR_CYC-edge register write window after KEY1..KEY2.
module wdt_unlock
    import wdt_pkg::*;
#(
    parameter int unsigned   DW     = 8,
    parameter int unsigned   WR_CYC = 4,
    parameter logic [DW-1:0] KEY1   = DW'(8'hAA),
    parameter logic [DW-1:0] KEY2   = DW'(8'h55)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    abus,
    input  logic [DW-1:0] dbus,
    output logic          wr_en,
    output logic [3:0]    wr_sel_c
);
    localparam int unsigned CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;

    unlock_state_t st, st_nx;
    logic [CW-1:0] wcnt, wcnt_nx;

    // wr_en is registered from the next state so it tracks the OPEN window exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= U_LOCKED;
            wcnt  <= '0;
            wr_en <= 1'b0;
        end else begin
            st    <= st_nx;
            wcnt  <= wcnt_nx;
            wr_en <= (st_nx == U_OPEN);
        end
    end

    always_comb begin
        st_nx   = st;
        wcnt_nx = wcnt;
        unique case (st)
            U_LOCKED: begin
                if (dbus == KEY1 && abus == A_FRAME) st_nx = U_ARMED;
            end
            U_ARMED: begin
                if (dbus != KEY1) begin
                    if (dbus == KEY2) begin
                        st_nx   = U_OPEN;
                        wcnt_nx = '0;
                    end else begin
                        st_nx = U_LOCKED;
                    end
                end
            end
            U_OPEN: begin
                if (wcnt == CW'(WR_CYC - 1)) st_nx = U_LOCKED;
                else                         wcnt_nx = wcnt + CW'(1);
            end
            default: st_nx = U_LOCKED;
        endcase
    end

    assign wr_sel_c = wr_en ? 4'(4'd1 << abus) : 4'd0;
endmodule

// File: rtl/wdt_window_gen2.sv
// Windowed watchdog with timeout-only mode and fault threshold.
// Optional frame-tick prescaler enabled by WDT_PRESCALE_EN.
module wdt_window_gen2
    import wdt_pkg::*;
#(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   WR_CYC   = 4,
    parameter logic [DW-1:0] KEY1     = DW'(8'hAA),
    parameter logic [DW-1:0] KEY2     = DW'(8'h55),
    parameter int unsigned   FAIL_LIM = 1
`ifdef WDT_PRESCALE_EN
    , parameter int unsigned PRE_LOG2 = 4
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [1:0]    ABUS,
    input  logic [DW-1:0] DBUS,
    output logic          RSTOUT,
    output logic          WDFAIL,
    output logic [2:0]    FLSTAT
);
    localparam int unsigned CW = DW + 1;

    wdt_state_t        st, st_nx;
    logic [DW-1:0]     frame, service, rstlim;
    logic              mode;
    logic [DW-1:0]     cnt, cnt_nx, rcnt, rcnt_nx;
    logic [FCNT_W-1:0] fcnt, fcnt_nx, fcnt_inc;
    logic              rstout_nx, wdfail_nx;
    logic [2:0]        flstat_nx, code;
    logic              wr_en, kick, tick, accept, cfg_ok, in_win, tmo;
    logic [3:0]        wr_sel_c;

    wdt_unlock #(.DW(DW), .WR_CYC(WR_CYC), .KEY1(KEY1), .KEY2(KEY2)) u_unlock (
        .clk      (CLK),
        .rst_n    (RST),
        .abus     (ABUS),
        .dbus     (DBUS),
        .wr_en    (wr_en),
        .wr_sel_c (wr_sel_c)
    );

    // Config registers; KICK is not stored, it only acts on its write edge
    always_ff @(posedge CLK) begin
        if (!RST) begin
            frame   <= '0;
            service <= '0;
            rstlim  <= '0;
            mode    <= 1'b0;
        end else begin
            if (wr_sel_c[A_FRAME]) frame   <= DBUS;
            if (wr_sel_c[A_SERV])  service <= DBUS;
            if (wr_sel_c[A_RLIM])  rstlim  <= DBUS;
            if (wr_sel_c[A_CTRL])  mode    <= DBUS[MODE_B];
        end
    end

    assign kick     = wr_en && (ABUS == A_CTRL) && DBUS[KICK_B];
    assign cfg_ok   = (frame != '0) && (service <= frame);
    // Widened sums keep the window/timeout tests correct after FRAME/SERVICE rewrites
    assign in_win   = (CW'(cnt) + CW'(service)) >= CW'(frame);
    assign tmo      = (CW'(cnt) + CW'(1)) >= CW'(frame);
    assign fcnt_inc = (fcnt == {FCNT_W{1'b1}}) ? fcnt : fcnt + FCNT_W'(1);

`ifdef WDT_PRESCALE_EN
    logic [PRE_LOG2-1:0] div;

    always_ff @(posedge CLK) begin
        if (!RST || accept) div <= '0;
        else                div <= div + PRE_LOG2'(1);
    end

    assign tick = &div;
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            st     <= W_IDLE;
            cnt    <= '0;
            rcnt   <= '0;
            fcnt   <= '0;
            RSTOUT <= 1'b0;
            WDFAIL <= 1'b0;
            FLSTAT <= FLT_NONE;
        end else begin
            st     <= st_nx;
            cnt    <= cnt_nx;
            rcnt   <= rcnt_nx;
            fcnt   <= fcnt_nx;
            RSTOUT <= rstout_nx;
            WDFAIL <= wdfail_nx;
            FLSTAT <= flstat_nx;
        end
    end

    always_comb begin
        st_nx     = st;
        cnt_nx    = cnt;
        rcnt_nx   = rcnt;
        fcnt_nx   = fcnt;
        rstout_nx = 1'b0;
        wdfail_nx = WDFAIL;
        flstat_nx = FLSTAT;
        accept    = 1'b0;
        code      = FLT_NONE;
        unique case (st)
            W_IDLE: begin
                if (kick) begin
                    if (cfg_ok) begin
                        st_nx  = W_RUN;
                        cnt_nx = '0;
                        accept = 1'b1;
                    end else begin
                        flstat_nx = FLT_CFG;
                    end
                end
            end
            W_RUN: begin
                // A kick on the timeout edge is serviced, not faulted
                if (kick && (mode || in_win)) begin
                    cnt_nx  = '0;
                    fcnt_nx = '0;
                    accept  = 1'b1;
                end else if (kick) begin
                    code = FLT_EARLY;
                end else if (tick && tmo) begin
                    code = FLT_TMO;
                end else if (tick) begin
                    cnt_nx = cnt + DW'(1);
                end
                if (code != FLT_NONE) begin
                    flstat_nx = code;
                    fcnt_nx   = fcnt_inc;
                    if (fcnt_inc >= FCNT_W'(FAIL_LIM)) wdfail_nx = 1'b1;
                    st_nx     = W_RSTP;
                    rcnt_nx   = (rstlim == '0) ? DW'(1) : rstlim;
                end
            end
            W_RSTP: begin
                if (rcnt != '0) begin
                    rstout_nx = 1'b1;
                    rcnt_nx   = rcnt - DW'(1);
                end else begin
                    st_nx = W_IDLE;
                end
            end
            default: st_nx = W_IDLE;
        endcase
    end
endmodule

// File: tb/tb_wdt_window_gen2.sv
// Randomized bench for wdt_window_gen2 against a behavioural model of the watchdog rules.
module tb_wdt_window_gen2;
    localparam int unsigned DW       = 8;
    localparam int unsigned WR_CYC   = 4;
    localparam logic [7:0]  KEY1     = 8'hAA;
    localparam logic [7:0]  KEY2     = 8'h55;
    localparam int unsigned FAIL_LIM = 2;
`ifdef WDT_PRESCALE_EN
    localparam int P = 16;
`else
    localparam int P = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] ABUS = 2'd1;
    logic [7:0] DBUS = 8'h00;
    logic       RSTOUT, WDFAIL;
    logic [2:0] FLSTAT;

    always #5 CLK = ~CLK;

    wdt_window_gen2 #(.DW(DW), .WR_CYC(WR_CYC), .KEY1(KEY1), .KEY2(KEY2), .FAIL_LIM(FAIL_LIM)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .RSTOUT (RSTOUT),
        .WDFAIL (WDFAIL),
        .FLSTAT (FLSTAT)
    );

    int checks = 0, errors = 0, hi_cnt = 0;
    int cyc = 0;

    // Model state: write-window slots left, arm flag, config, watchdog phase (0 idle, 1 run, 2 pulse)
    int   u_left, m_frame, m_serv, m_rlim, phase, m_cnt, m_div, m_fcnt, f_edge, f_len, t_kick, code;
    bit   u_armed, m_mode, wr, kick, tick, m_rstout, m_wdfail;
    logic [2:0] m_flstat;

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            u_left = 0; u_armed = 0; m_frame = 0; m_serv = 0; m_rlim = 0; m_mode = 0;
            phase = 0; m_cnt = 0; m_div = 0; m_fcnt = 0;
            m_rstout = 0; m_wdfail = 0; m_flstat = 3'b000;
        end else begin
            wr   = (u_left > 0);
            kick = wr && (ABUS == 2'd2) && DBUS[3];
            if (u_left > 0) u_left--;
            else if (u_armed) begin
                if (DBUS == KEY2) begin u_armed = 0; u_left = WR_CYC; end
                else if (DBUS != KEY1) u_armed = 0;
            end else u_armed = (DBUS == KEY1) && (ABUS == 2'd0);
            tick  = (m_div == P - 1);
            m_div = (m_div + 1) % P;
            code  = 0;
            case (phase)
                0: if (kick) begin
                    if (m_frame != 0 && m_serv <= m_frame) begin
                        phase = 1; m_cnt = 0; m_div = 0; t_kick = cyc;
                    end else m_flstat = 3'b100;
                end
                1: begin
                    if (kick && (m_mode || m_cnt >= m_frame - m_serv)) begin
                        m_cnt = 0; m_fcnt = 0; m_div = 0; t_kick = cyc;
                    end else if (kick) code = 3;
                    else if (tick && m_cnt >= m_frame - 1) code = 1;
                    else if (tick) m_cnt++;
                end
                default: begin
                    if (cyc > f_edge + f_len) begin phase = 0; m_rstout = 0; end
                    else m_rstout = 1;
                end
            endcase
            if (code != 0) begin
                m_flstat = 3'(code);
                m_fcnt   = (m_fcnt < 15) ? m_fcnt + 1 : 15;
                if (m_fcnt >= int'(FAIL_LIM)) m_wdfail = 1;
                phase  = 2;
                f_edge = cyc;
                f_len  = (m_rlim == 0) ? 1 : m_rlim;
            end
            if (wr) begin
                case (ABUS)
                    2'd0: m_frame = int'(DBUS);
                    2'd1: m_serv  = int'(DBUS);
                    2'd3: m_rlim  = int'(DBUS);
                    default: m_mode = DBUS[0];
                endcase
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        checks++;
        if ({RSTOUT, WDFAIL, FLSTAT} !== {m_rstout, m_wdfail, m_flstat}) begin
            errors++;
            $display("FAIL outputs cyc=%0d got rstout=%b wdfail=%b flstat=%b exp rstout=%b wdfail=%b flstat=%b",
                     cyc, RSTOUT, WDFAIL, FLSTAT, m_rstout, m_wdfail, m_flstat);
        end
        if (RSTOUT === 1'b1) hi_cnt++;
        if (cyc > 90000) begin
            $display("FAIL cycle_budget cyc=%0d exceeded", cyc);
            $fatal(1, "cycle budget exceeded");
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ABUS = a;
        DBUS = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'd1, 8'h00);
    endtask

    task automatic unlock();
        drive(2'd0, KEY1);
        drive(2'd0, KEY1);
        drive(2'd0, KEY2);
    endtask

    task automatic window(input logic [1:0] a0, input logic [7:0] d0, input logic [1:0] a1, input logic [7:0] d1,
                          input logic [1:0] a2, input logic [7:0] d2, input logic [1:0] a3, input logic [7:0] d3);
        drive(a0, d0); drive(a1, d1); drive(a2, d2); drive(a3, d3);
    endtask

    // Kick so that the kick edge sees counter value n; slot 4 carries 'last'
    task automatic kick_at(input int n, input logic [7:0] ctl, input logic [7:0] last);
        int e;
        e = t_kick + n * P + 1;
        while (cyc + 2 < e - 2) idle(1);
        drive(2'd0, KEY1);
        drive(2'd0, KEY2);
        window(2'd2, ctl, 2'd2, ctl & 8'h01, 2'd2, ctl & 8'h01, 2'd2, last);
    endtask

    task automatic wait_fl(input logic [2:0] c, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 12 * P + 40; i++) begin
            if (FLSTAT == c) begin found = 1; break; end
            idle(1);
        end
        chk(name, int'(found), 1);
    endtask

    task automatic wait_rst(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 12 * P + 40; i++) begin
            if (RSTOUT == 1'b1) begin found = 1; break; end
            idle(1);
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        int t0;
        logic [1:0] a;
        logic [7:0] d;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'({RSTOUT, WDFAIL, FLSTAT}), 0);
        RST = 1'b1;

        // Config FRAME=10 SERVICE=3 RSTLIM=4, start, then service at counter 8
        unlock();
        window(2'd0, 8'h0A, 2'd1, 8'h03, 2'd3, 8'h04, 2'd2, 8'h00);
        idle(2);
        hi_cnt = 0;
        unlock();
        window(2'd2, 8'h08, 2'd2, 8'h00, 2'd2, 8'h00, 2'd2, 8'h00);
        kick_at(8, 8'h08, 8'h00);
        idle(3);
        chk("good_kick_flstat", int'(FLSTAT), 0);
        chk("good_kick_rstout", hi_cnt, 0);

        // Good kick then an early kick three edges later
        hi_cnt = 0;
        kick_at(8, 8'h08, 8'h08);
        idle(8);
        chk("early_flstat", int'(FLSTAT), 3);
        chk("early_pulse_len", hi_cnt, 4);
        chk("early_wdfail_first", int'(WDFAIL), 0);

        // Broken key sequence: nothing written, no kick
        hi_cnt = 0;
        drive(2'd0, KEY1); drive(2'd0, 8'h33);
        drive(2'd0, 8'h00); drive(2'd2, 8'h08); drive(2'd2, 8'h08); drive(2'd1, 8'h00);
        idle(3);
        chk("badkey_flstat", int'(FLSTAT), 3);
        chk("badkey_rstout", hi_cnt, 0);

        // Start and let it time out
        unlock();
        window(2'd2, 8'h08, 2'd2, 8'h00, 2'd2, 8'h00, 2'd2, 8'h00);
        t0 = t_kick;
        hi_cnt = 0;
        wait_fl(3'b001, "tmo_seen");
        chk("tmo_latency", cyc - t0, 10 * P);
        idle(8);
        chk("tmo_pulse_len", hi_cnt, 4);
        chk("tmo_wdfail_second", int'(WDFAIL), 1);

        // FRAME=0 makes the start kick a config fault
        unlock();
        window(2'd0, 8'h00, 2'd1, 8'h03, 2'd3, 8'h04, 2'd2, 8'h00);
        hi_cnt = 0;
        unlock();
        window(2'd2, 8'h08, 2'd2, 8'h00, 2'd2, 8'h00, 2'd2, 8'h00);
        idle(6);
        chk("cfg_flstat", int'(FLSTAT), 4);
        chk("cfg_rstout", hi_cnt, 0);

        // Reset, timeout-only mode, threshold of two faults, reset during pulse
        RST = 1'b0;
        idle(2);
        chk("rst_mid_outputs", int'({RSTOUT, WDFAIL, FLSTAT}), 0);
        RST = 1'b1;
        unlock();
        window(2'd0, 8'h0A, 2'd1, 8'h03, 2'd3, 8'h04, 2'd2, 8'h01);
        unlock();
        window(2'd2, 8'h09, 2'd2, 8'h01, 2'd2, 8'h01, 2'd2, 8'h09);
        idle(2);
        chk("mode1_early_ok", int'(FLSTAT), 0);
        wait_fl(3'b001, "mode1_tmo1");
        idle(8);
        chk("mode1_wdfail_after1", int'(WDFAIL), 0);
        unlock();
        window(2'd2, 8'h09, 2'd2, 8'h01, 2'd2, 8'h01, 2'd2, 8'h01);
        wait_rst("mode1_tmo2");
        chk("mode1_wdfail_after2", int'(WDFAIL), 1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_pulse", int'({RSTOUT, WDFAIL, FLSTAT}), 0);
        RST = 1'b1;

        // Randomized traffic
        repeat (60) begin
            if ($urandom_range(0, 29) == 0) begin RST = 1'b0; idle(2); RST = 1'b1; end
            idle($urandom_range(0, 12));
            drive(2'd0, KEY1);
            if ($urandom_range(0, 1) == 1) drive(2'($urandom_range(0, 3)), KEY1);
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 8'h33 : KEY2);
            for (int i = 0; i < 4; i++) begin
                a = 2'($urandom_range(0, 3));
                case (a)
                    2'd0:    d = 8'($urandom_range(0, 14));
                    2'd1:    d = 8'($urandom_range(0, 10));
                    2'd3:    d = 8'($urandom_range(0, 5));
                    default: d = 8'($urandom) & 8'h09;
                endcase
                drive(a, d);
            end
            idle($urandom_range(0, 25 * P));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wdt_window_gen2.md
Name: wdt_window_gen2

Overview:
- Parametrised successor to the single-channel windowed watchdog: configurable bus width, unlock key values and unlock-window length.
- Adds a timeout-only mode and a consecutive-fault threshold before the sticky failure flag.
- Sits on the same ABUS/DBUS config path. Drives the system reset request (RSTOUT) and fault status to the top level.

Parameters:
- DW, 8, data bus and register width. Frame, service and reset counters are DW wide.
- WR_CYC, 4, number of write cycles opened by a valid unlock sequence.
- KEY1, 8'hAA (zero-extended to DW), first unlock key.
- KEY2, 8'h55 (zero-extended to DW), second unlock key.
- FAIL_LIM, 1, number of consecutive faults before WDFAIL asserts. Legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- ABUS  in  2  register address.
- DBUS  in  DW  data, sampled every rising edge (no strobe).
- RSTOUT  out  1  reset request pulse.
- WDFAIL  out  1  sticky failure flag.
- FLSTAT  out  3  last fault code.

Behaviour:
- Reset (RST=0 at edge):
  - RSTOUT=0, WDFAIL=0, FLSTAT=000.
  - FRAME, SERVICE, RSTLIM and CTRL all 0. Fault count 0.
  - Unlock FSM in LOCKED; watchdog FSM in IDLE.
  - Applies mid-operation, including during a reset pulse.
- Unlock FSM, states LOCKED, ARMED, OPEN:
  - LOCKED -> ARMED when DBUS==KEY1 and ABUS==00.
  - ARMED stays ARMED while DBUS==KEY1.
  - ARMED -> OPEN when DBUS==KEY2.
  - ARMED -> LOCKED on any other value.
  - OPEN lasts exactly WR_CYC edges, starting at the edge after KEY2. On each of these edges DBUS is written to the register at ABUS, then the FSM returns to LOCKED.
  - KEY1 seen during OPEN is a data write, not a re-arm.
- Register map:
  - 00 FRAME: frame length in ticks.
  - 01 SERVICE: open-window length.
  - 11 RSTLIM: RSTOUT pulse length.
  - 10 CTRL: bit3 KICK (self-clearing, acts on the write edge only), bit0 MODE (0 = window, 1 = timeout-only).
  - Writes take effect from the next edge.
- Config valid when FRAME!=0 and SERVICE<=FRAME.
- Watchdog FSM, states IDLE, RUN, RSTP:
  - IDLE, KICK with valid config -> RUN, counter cleared to 0.
  - IDLE, KICK with invalid config -> stays IDLE, FLSTAT=100, no pulse, fault count unchanged.
  - RUN: counter increments each tick.
  - RUN, KICK with counter>=FRAME-SERVICE (or any counter value in MODE=1) -> good service. Counter cleared, fault count cleared, FLSTAT unchanged.
  - RUN, KICK with counter<FRAME-SERVICE in MODE=0 -> early fault, code 011.
  - RUN, counter==FRAME-1 with no KICK on that edge -> timeout fault, code 001.
  - KICK on the same edge as timeout -> good service (kick wins).
  - On any RUN fault: FLSTAT=code, fault count +1 (saturating), -> RSTP.
  - RSTP: RSTOUT=1 for max(RSTLIM,1) cycles starting the edge after the fault. RSTLIM is latched on entry.
  - RSTP -> IDLE when the pulse ends.
  - KICK writes during RSTP are ignored; configuration writes are still accepted.
- WDFAIL=1 on the edge the fault count reaches FAIL_LIM; stays set until RST.
- FRAME/SERVICE rewrites during RUN apply immediately to comparisons. If the counter is already >=FRAME, a timeout fires on the next tick.

Optional Feature:
- Macro WDT_PRESCALE_EN.
- Defined: adds parameter PRE_LOG2 (default 4). The frame counter advances only on a tick from a free-running 2^PRE_LOG2 divider; the divider is cleared on RST and on a good kick. RSTOUT pulse length stays in clocks.
- Not defined: tick every clock, no divider logic.

Decomposition:
- Package wdt_pkg:
  - Fault codes FLT_NONE=000, FLT_TMO=001, FLT_EARLY=011, FLT_CFG=100.
  - Address constants A_FRAME=00, A_SERV=01, A_CTRL=10, A_RLIM=11.
  - CTRL bit indices KICK_B=3, MODE_B=0.
  - State typedefs for both FSMs.
- Sub-module wdt_unlock: key sequence detector plus WR_CYC write-window counter. Outputs wr_en (write enable) and a write-address valid signal.

Test Plan:
- Config: AA, AA, 55 then writes 0A@00, 03@01, 04@11, 00@10. Later kick with 08@10 at counter=8 -> RSTOUT stays 0, FLSTAT=000.
- Same config, two kicks 4 cycles apart (second at counter=3) -> FLSTAT=011, RSTOUT high exactly 4 cycles, WDFAIL=1 (FAIL_LIM=1).
- Kick once, then no further writes -> at counter=9 edge FLSTAT=001, RSTOUT 4 cycles, FSM back in IDLE.
- AA then 33 then data writes -> no register change. Kick with FRAME=0 -> FLSTAT=100, RSTOUT=0.
- FAIL_LIM=2, MODE=1: timeout, re-kick, timeout -> WDFAIL rises only after the second fault. Apply RST low during the pulse -> all outputs 0 next edge.
- WDT_PRESCALE_EN, PRE_LOG2=2, FRAME=0A: timeout after 40 clocks, not 10.
